// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-ported data memory.
// Each transaction runs IDLE -> ACCESS -> RESP; faulty addresses never reach memory.
module dmem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MEM_WORDS      = 32,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(4 * MEM_WORDS);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e state_q;
    logic   last_grant_q;
    logic   grant_q;
    logic   we_q;
    logic   fault_q;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_fault;

    always_comb begin
        sel = p1_req;
        if (p0_req && p1_req) begin
            sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end
        sel_we    = sel ? p1_we    : p0_we;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        // Fault is decided at grant time; the latched request cannot change afterwards.
        sel_fault = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= AddrLimit);
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            fault_q      <= 1'b0;
            p0_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p0_rdata     <= '0;
            p1_ack       <= 1'b0;
            p1_err       <= 1'b0;
            p1_rdata     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        grant_q      <= sel;
                        last_grant_q <= sel;
                        we_q         <= sel_we;
                        fault_q      <= sel_fault;
                        // Memory strobes are registered so they are high exactly during ACCESS.
                        if (!sel_fault) begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_wr    <= sel_we;
                            mem_rd    <= ~sel_we;
                        end
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (!fault_q && !we_q) begin
                        if (grant_q) begin
                            p1_rdata <= mem_rdata;
                        end else begin
                            p0_rdata <= mem_rdata;
                        end
                    end
                    p0_ack  <= ~grant_q;
                    p1_ack  <= grant_q;
                    p0_err  <= ~grant_q & fault_q;
                    p1_err  <= grant_q & fault_q;
                    state_q <= StResp;
                end
                StResp: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_err  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, contention and reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;

    logic        p0_ack, p0_err, p1_ack, p1_err, mem_rd, mem_wr, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        p0_ack_b, p0_err_b, p1_ack_b, p1_err_b, mem_rd_b, mem_wr_b, busy_b;
    logic [31:0] p0_rdata_b, p1_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack_b), .p0_err(p0_err_b), .p0_rdata(p0_rdata_b),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack_b), .p1_err(p1_err_b), .p1_rdata(p1_rdata_b),
        .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    // Data memories: asynchronous read, write on the clock edge; contents survive rst.
    assign mem_rdata   = mem_a[mem_addr[6:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[6:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= (i == 0) ? 32'hF : (i == 1) ? 32'hC : 32'h0;
                mem_b[i] <= (i == 0) ? 32'hF : (i == 1) ? 32'hC : 32'h0;
            end
        end else begin
            if (mem_wr)   mem_a[mem_addr[6:2]]   <= mem_wdata;
            if (mem_wr_b) mem_b[mem_addr_b[6:2]] <= mem_wdata_b;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[10];

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rd);
        int   n = 0, wr_cnt = 0, rd_cnt = 0;
        logic got = 1'b0, other = 1'b0;
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wdata);
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            wr_cnt += int'(mem_wr);
            rd_cnt += int'(mem_rd);
            other  |= (port == 0) ? p1_ack : p0_ack;
            got     = (port == 0) ? p0_ack : p1_ack;
        end
        check("ack_cycle", n, 3);
        check("err", (port == 0) ? p0_err : p1_err, exp_err);
        check("rdata", (port == 0) ? p0_rdata : p1_rdata, exp_rd);
        check("mem_wr_cycles", wr_cnt, (!exp_err && we) ? 1 : 0);
        check("mem_rd_cycles", rd_cnt, (!exp_err && !we) ? 1 : 0);
        check("other_port_ack", other, 0);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        if (r == 1) return 32'h80 + {$urandom_range(0, 255), 2'b00};
        return {25'h0, 5'($urandom_range(0, 31)), 2'b00};
    endfunction

    // Transaction-level reference model state for the random phase.
    logic [31:0] ref_mem [32];
    logic [31:0] m_rd [2];
    int          cyc, free_at, ack_due, ack_port, m_last, w;
    logic        ack_err, act0, act1, seen0, seen1, bad_addr, m_we;
    logic [31:0] ack_rd, a, wd;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h04, 32'h0,        1'b0, 32'h0000000C};
        vecs[1] = '{1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[2] = '{0, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3] = '{0, 1'b0, 32'h06, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[4] = '{1, 1'b1, 32'h80, 32'h12345678, 1'b1, 32'h00000000};
        vecs[5] = '{1, 1'b1, 32'h7C, 32'hA5A5A5A5, 1'b0, 32'h00000000};
        vecs[6] = '{1, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[7] = '{0, 1'b0, 32'h80, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[8] = '{0, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0000000F};
        vecs[9] = '{1, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};

        // Reset state
        rst = 1'b1; mem_init = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0;
        check("reset_flags", {p0_ack, p0_err, p1_ack, p1_err, mem_rd, mem_wr, busy}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_p0_rdata", p0_rdata, 0);
        check("reset_p1_rdata", p1_rdata, 0);
        check("fp_reset_flags",
              {p0_ack_b, p0_err_b, p1_ack_b, p1_err_b, mem_rd_b, mem_wr_b, busy_b}, 0);
        check("fp_reset_data", mem_wdata_b | p1_rdata_b, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].err, vecs[i].rd);
        end

        // Continuous contention: both instances see the same two held loads.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check($sformatf("rr_p0_ack_c%0d", n), p0_ack, (n % 6 == 3) ? 1 : 0);
            check($sformatf("rr_p1_ack_c%0d", n), p1_ack, (n % 6 == 0) ? 1 : 0);
            check($sformatf("fp_p0_ack_c%0d", n), p0_ack_b, (n % 3 == 0) ? 1 : 0);
            check($sformatf("fp_p1_ack_c%0d", n), p1_ack_b, 0);
        end
        check("rr_p0_rdata", p0_rdata, 32'hF);
        check("rr_p1_rdata", p1_rdata, 32'hC);
        check("fp_p0_rdata", p0_rdata_b, 32'hF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);

        // Reset during ACCESS of a store: no ack, write lost.
        #1 drive(1, 1'b1, 1'b1, 32'hC, 32'h55AA55AA);
        @(posedge clk); #2;
        check("abort_busy_before", busy, 1);
        check("abort_mem_wr_before", mem_wr, 1);
        rst = 1'b1;
        #1;
        check("abort_busy_after", busy, 0);
        check("abort_mem_wr_after", mem_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        seen0 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            seen0 |= p0_ack | p1_ack;
        end
        check("abort_no_ack", seen0, 0);
        do_txn(0, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        rst = 1'b1; mem_init = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        mem_init = 1'b0; rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = (i == 0) ? 32'hF : (i == 1) ? 32'hC : 32'h0;
        m_rd[0] = '0; m_rd[1] = '0;
        cyc = 0; free_at = 0; ack_due = -1; ack_port = 0; ack_err = 1'b0; ack_rd = '0;
        m_last = 1; act0 = 1'b0; act1 = 1'b0;
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            cyc++;
            if (cyc == ack_due) m_rd[ack_port] = ack_rd;
            check("rand_p0_ack", p0_ack, (cyc == ack_due && ack_port == 0) ? 1 : 0);
            check("rand_p1_ack", p1_ack, (cyc == ack_due && ack_port == 1) ? 1 : 0);
            if (cyc == ack_due) check("rand_err", ack_port ? p1_err : p0_err, ack_err);
            check("rand_p0_rdata", p0_rdata, m_rd[0]);
            check("rand_p1_rdata", p1_rdata, m_rd[1]);
            seen0 = p0_ack;
            seen1 = p1_ack;
            if (cyc >= free_at && (p0_req || p1_req)) begin
                w      = (p0_req && p1_req) ? 1 - m_last : (p1_req ? 1 : 0);
                m_last = w;
                a      = w ? p1_addr : p0_addr;
                wd     = w ? p1_wdata : p0_wdata;
                m_we   = w ? p1_we : p0_we;
                bad_addr = (a % 4 != 0) || (a >= 128);
                ack_rd = m_rd[w];
                if (!bad_addr) begin
                    if (m_we) ref_mem[a / 4] = wd;
                    else      ack_rd = ref_mem[a / 4];
                end
                ack_due = cyc + 2; ack_port = w; ack_err = bad_addr; free_at = cyc + 3;
            end
            @(posedge clk); #1;
            if (act0 && seen0) act0 = 1'b0;
            if (act1 && seen1) act1 = 1'b0;
            if (!act0 && $urandom_range(0, 99) < 45) begin
                act0 = 1'b1;
                drive(0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            if (!act1 && $urandom_range(0, 99) < 45) begin
                act1 = 1'b1;
                drive(1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            p0_req = act0;
            p1_req = act1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 32-word data memory.
- Shares the single memory port between port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Runs a fixed 3-state transaction FSM with round-robin or fixed-priority arbitration.
- Returns read data and a one-cycle ack per transaction; flags misaligned and out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width.
- MEM_WORDS, 32, number of memory words; valid byte addresses are 0 to 4*MEM_WORDS-1.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write enable (1 = store, 0 = load).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 store data.
- p0_ack  out  1  one-cycle transaction-done pulse.
- p0_err  out  1  valid only with p0_ack; address fault.
- p0_rdata  out  DATA_W  load data; holds until the next port 0 read ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_rd  out  1  to memory read flag.
- mem_wr  out  1  to memory write flag.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write value.
- mem_rdata  in  DATA_W  from memory asynchronous read output.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All acks, errs, mem_rd, mem_wr and busy = 0; mem_addr, mem_wdata, p0_rdata and p1_rdata = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high: with FIXED_PRIORITY=0, grant the port != last_grant; with FIXED_PRIORITY=1, grant port 0.
  - On grant, latch port id, we, addr and wdata; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - Latched address is faulty if addr[1:0]!=0 or addr >= 4*MEM_WORDS.
  - If faulty: mem_rd=mem_wr=0; set err flag; go to RESP.
  - Otherwise: mem_addr and mem_wdata come from the latched values; mem_wr = latched we, mem_rd = !latched we.
  - The memory write commits on the closing edge of ACCESS.
  - For a load, mem_rdata is captured into the granted port's rdata register on the closing edge.
  - Go to RESP.
- RESP (1 cycle):
  - Granted port's ack=1; its err = latched fault flag; mem_rd=mem_wr=0.
  - Go to IDLE unconditionally.
- Fixed latency: ack occurs 3 cycles after the IDLE cycle in which req is sampled with a grant. Minimum spacing between back-to-back transactions is 3 cycles.
- Requester rules:
  - req, we, addr and wdata must be stable from assertion until ack.
  - In the cycle after ack, req is either low or a new request.
  - Requester inputs are ignored outside IDLE.
- The ungranted port keeps waiting with no ack. Under continuous contention, round-robin alternates ports: neither waits more than one transaction.
- A faulty load does not update rdata.
- Outside ACCESS: mem_rd=mem_wr=0; mem_addr and mem_wdata hold their last driven values.
- Reset mid-transaction: the transaction is aborted with no ack. Any write not yet committed at an edge is lost.
- p0_ack and p1_ack are never high in the same cycle.

Test Plan:
- After reset (data memory reset contents word0=0x0000000F, word1=0x0000000C), p0 load addr 0x4 -> p0_ack in cycle 3, p0_rdata=0x0000000C, p0_err=0, mem_wr never high.
- p1 store 0xDEADBEEF to addr 0x8, then p0 load 0x8 -> mem_wr high for exactly 1 cycle; p0_rdata=0xDEADBEEF.
- Both req high continuously (loads of 0x0 and 0x4), FIXED_PRIORITY=0 -> ack order p0,p1,p0,p1; ack spacing 3 cycles; p1_rdata=0x0000000C.
- Same contention with FIXED_PRIORITY=1 -> p0 acked every 3 cycles; p1 never acked while p0_req is held.
- p0 load 0x6 (misaligned) and p1 store to 0x80 (out of range) -> each acked with err=1; mem_rd/mem_wr stay 0; memory and rdata unchanged.
- rst asserted during ACCESS of a p1 store to 0xC -> no ack; busy=0 immediately; subsequent load of 0xC returns 0x00000000.
